// File: rtl/cdb_arbiter_if.sv
// Common data bus arbitration interface: functional-unit requests,
// pipeline control (stall/flush) and the registered CDB broadcast.
interface cdb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic [3:0]         req_valid;
    logic [4*TAG_W-1:0] req_tag;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_grant;
    logic               cdb_stall;
    logic               flush;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [WIDTH-1:0]   cdb_data;
    logic [1:0]         cdb_src;

    // Pipeline side: functional units and control drive requests.
    modport master (
        output req_valid, req_tag, req_data, cdb_stall, flush,
        input  req_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_data, cdb_stall, flush,
        output req_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter for four functional units (ALU, MUL/DIV, LSU,
// branch). Grants at most one requester per cycle, steers its tag/result
// through a 4-way select and registers the broadcast. The priority pointer
// moves past each winner so a continuously valid unit waits at most three
// transfers. Stall freezes the broadcast, flush cancels it.
module cdb_arbiter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);

    logic [1:0]       ptr_q,   ptr_d;
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [1:0]       src_q,   src_d;

    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             take;
    logic [3:0]       grant;

    function automatic logic [TAG_W-1:0] mux4_tag(input logic [4*TAG_W-1:0] tags,
                                                   input logic [1:0] sel);
        return tags[sel*TAG_W +: TAG_W];
    endfunction

    function automatic logic [WIDTH-1:0] mux4_data(input logic [4*WIDTH-1:0] data,
                                                    input logic [1:0] sel);
        return data[sel*WIDTH +: WIDTH];
    endfunction

    // Rotating search: first valid requester starting at the priority pointer.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // A transfer happens only when nothing in the pipeline blocks the bus.
    assign take = found && !rst && !bus.flush && !bus.cdb_stall;

    // One-hot grant to the winner; zero whenever no transfer takes place.
    always_comb begin
        grant = 4'b0000;
        if (take) begin
            grant[win] = 1'b1;
        end
    end

    assign bus.req_grant = grant;

    // Next broadcast: flush cancels, stall holds, otherwise load the winner
    // or drop valid when idle.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        src_d   = src_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (bus.cdb_stall) begin
            valid_d = valid_q;
        end else if (found) begin
            valid_d = 1'b1;
            tag_d   = mux4_tag(bus.req_tag, win);
            data_d  = mux4_data(bus.req_data, win);
            src_d   = win;
            ptr_d   = win + 2'd1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Broadcast and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            src_q   <= 2'd0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign bus.cdb_valid = valid_q;
    assign bus.cdb_tag   = tag_q;
    assign bus.cdb_data  = data_q;
    assign bus.cdb_src   = src_q;

endmodule
